pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit for the MIPS fetch stage. Successor to the plain increment-by-4 PC.
- Holds the current fetch address and advances it by 4.
- Adds stall/backpressure hold, branch/jump redirect, exception entry/return with EPC, and a small return-address stack (RAS) for call/return.
- Sits between the fetch address mux and instruction memory. Driven by the decode/execute control and the hazard unit.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 0, pc_out value after reset.
- EXC_VECTOR, 32'h0000_0080, exception handler address.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard hold; pc_out keeps its value
- fetch_ready  in  1  imem accepts address; low = hold
- branch_taken  in  1  redirect to branch_target
- branch_target  in  WIDTH  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  WIDTH  jump destination; also the fallback for ret
- call  in  1  qualifies jump: push pc_out+4 on RAS
- ret  in  1  pop RAS and redirect to the popped value
- exc  in  1  take exception
- eret  in  1  return from exception to epc_out
- pc_out  out  WIDTH  current fetch address
- pc_valid  out  1  pc_out is a valid fetch address
- epc_out  out  WIDTH  saved exception PC
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- misalign  out  1  one-cycle pulse: a redirect target had bits[1:0]≠0

Behaviour:
- Reset (synchronous): pc_out=RESET_VECTOR, epc_out=0, pc_valid=0, RAS count=0 (ras_empty=1, ras_full=0), misalign=0. A reset asserted mid-operation discards any pending redirect or RAS activity.
- pc_valid goes to 1 on the first clock edge with reset low and stays 1.
- Next-PC priority, highest first, evaluated every edge:
  1. exc: epc_out<=pc_out; pc_out<=EXC_VECTOR.
  2. eret: pc_out<=epc_out.
  3. branch_taken: pc_out<=branch_target.
  4. ret: if RAS non-empty, pc_out<=top entry and the entry is popped. If empty, pc_out<=jump_target and the RAS is unchanged.
  5. jump: pc_out<=jump_target. If call is also high, push pc_out+4.
  6. stall | !fetch_ready: hold pc_out.
  7. Otherwise pc_out<=pc_out+4, modulo 2^WIDTH (all-ones−3 wraps to 0).
- Levels 1–5 override stall and fetch_ready. A redirect is a flush and always takes effect.
- A lower-priority request that loses in a cycle is dropped, not queued. In particular, RAS push/pop happen only when their redirect wins.
- call without jump is ignored.
- Every redirect target (levels 2–5) has bits[1:0] forced to 0. misalign=1 for exactly the following cycle if the raw target had bits[1:0]≠0.
- RAS is a circular stack:
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH, ras_full stays 1.
  - Pop when empty is a no-op.
  - Push and pop never occur in the same cycle, because priority excludes it.
- Latency: one cycle from any request to the new pc_out. No combinational path from inputs to outputs.

Decomposition:
- Package pc_pkg:
  - INSN_BYTES=4.
  - Redirect-source enum {SRC_RESET, SRC_EXC, SRC_ERET, SRC_BRANCH, SRC_RET, SRC_JUMP, SRC_HOLD, SRC_SEQ}.
  - Function align_word().
- Sub-module pc_ras(WIDTH, RAS_DEPTH):
  - Ports: clock, reset, push, pop, push_data, top, empty, full.
  - Holds the storage array, pointer and count.
- pc_unit contains the priority mux, the PC/EPC registers, and misalign/valid generation.

Test Plan:
- Reset then 3 free-running cycles, no requests → pc_out 0, 4, 8, 12; pc_valid 0 during reset, 1 after.
- stall=1 for 2 cycles at pc_out=0x10, with branch_taken=1 to 0x200 in the second stall cycle → pc_out holds 0x10, then 0x200, then 0x204.
- jump+call at pc_out=0x40 to 0x100, run to 0x108, then ret → pc_out 0x100…0x108, then 0x44; ras_empty returns to 1.
- RAS_DEPTH=4: 5 calls from pc 0x0, 0x100, 0x200, 0x300, 0x400 (each jump_target = next), then 5 rets with jump_target=0xF00 → pops 0x404, 0x304, 0x204, 0x104, then fallback 0xF00; ras_full=1 after the 4th call.
- exc at pc_out=0x24 simultaneous with branch_taken → pc_out=0x80, epc_out=0x24. Later eret → pc_out=0x24.
- jump to 0x103 → pc_out=0x100, misalign pulses 1 for one cycle. Then at pc_out=WIDTH max−3, no requests → next pc_out=0.

Source files
------------

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Shared definitions for the fetch-stage program-counter unit:
//             instruction size, next-PC source encoding and word alignment.
//  Revision : 1.0  initial release
// ============================================================================
package pc_pkg;

    // Bytes per instruction; sequential fetch advances by this amount.
    localparam int INSN_BYTES = 4;

    // Widest address the alignment helper handles.
    localparam int PC_MAX_WIDTH = 64;

    // Which source produced the next fetch address.
    typedef enum logic [2:0] {
        SRC_RESET  = 3'd0,
        SRC_EXC    = 3'd1,
        SRC_ERET   = 3'd2,
        SRC_BRANCH = 3'd3,
        SRC_RET    = 3'd4,
        SRC_JUMP   = 3'd5,
        SRC_HOLD   = 3'd6,
        SRC_SEQ    = 3'd7
    } pc_src_e;

    // Clear the byte-offset bits so the address lands on an instruction.
    // Callers zero-extend into and truncate back out of PC_MAX_WIDTH.
    function automatic logic [PC_MAX_WIDTH-1:0] align_word(
        input logic [PC_MAX_WIDTH-1:0] addr
    );
        return {addr[PC_MAX_WIDTH-1:2], 2'b00};
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras
//  Purpose  : Circular return-address stack. A push into a full stack
//             overwrites the oldest entry; a pop from an empty stack does
//             nothing. top is the most recently pushed live entry.
//  Ports    : clock, reset      - clock, synchronous active-high reset
//             push, push_data   - store push_data as the new top
//             pop               - discard the top entry
//             top               - current top entry (registered storage)
//             empty, full       - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;      // next slot to write
    logic [c_CNT_W-1:0] r_count;    // live entries, saturates at RAS_DEPTH

    logic               w_full;
    logic               w_empty;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(RAS_DEPTH));

    // Storage needs no reset: entries are only read while r_count says they
    // are live.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            r_mem[r_ptr] <= push_data;
        end
    end

    // The pointer wraps naturally because RAS_DEPTH is a power of two, so a
    // push when full lands on the oldest slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + c_PTR_W'(1);
            if (!w_full) begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end else if (pop && !w_empty) begin
            r_ptr   <= r_ptr - c_PTR_W'(1);
            r_count <= r_count - c_CNT_W'(1);
        end
    end

    assign top   = r_mem[r_ptr - c_PTR_W'(1)];
    assign empty = w_empty;
    assign full  = w_full;

endmodule : pc_ras
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Fetch-stage program counter with stall/backpressure hold,
//             branch/jump redirect, exception entry/return (EPC) and a
//             return-address stack for call/return.
//  Ports    : clock, reset                 - clock, sync active-high reset
//             stall, fetch_ready           - hold requests
//             branch_taken, branch_target  - branch redirect
//             jump, jump_target, call      - jump redirect, optional RAS push
//             ret                          - pop RAS and redirect
//             exc, eret                    - exception entry / return
//             pc_out, pc_valid             - current fetch address
//             epc_out                      - saved exception PC
//             ras_empty, ras_full          - RAS occupancy
//             misalign                     - redirect target was unaligned
//  Revision : 1.0  initial release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('h80),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic [WIDTH-1:0] epc_out,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] c_INSN_STEP = WIDTH'(INSN_BYTES);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_valid;
    logic             r_misalign;

    pc_src_e          w_src;
    logic [WIDTH-1:0] w_target_raw;
    logic [WIDTH-1:0] w_target;
    logic             w_redirect;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;
    logic             w_ras_full;

    // ------------------------------------------------------------------
    // Next-PC priority. Only the winning request acts; everything below
    // it in the chain is dropped, including RAS push/pop.
    // ------------------------------------------------------------------
    always_comb begin
        w_src        = SRC_SEQ;
        w_target_raw = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        if (exc) begin
            w_src = SRC_EXC;
        end else if (eret) begin
            w_src        = SRC_ERET;
            w_target_raw = r_epc;
        end else if (branch_taken) begin
            w_src        = SRC_BRANCH;
            w_target_raw = branch_target;
        end else if (ret) begin
            w_src = SRC_RET;
            // An empty stack falls back to the decoded jump target.
            if (!w_ras_empty) begin
                w_target_raw = w_ras_top;
                w_pop        = 1'b1;
            end else begin
                w_target_raw = jump_target;
            end
        end else if (jump) begin
            w_src        = SRC_JUMP;
            w_target_raw = jump_target;
            w_push       = call;
        end else if (stall || !fetch_ready) begin
            w_src = SRC_HOLD;
        end

        // Reset wins over everything and cancels pending stack activity.
        if (reset) begin
            w_src  = SRC_RESET;
            w_push = 1'b0;
            w_pop  = 1'b0;
        end
    end

    assign w_redirect = (w_src == SRC_ERET) || (w_src == SRC_BRANCH) ||
                        (w_src == SRC_RET)  || (w_src == SRC_JUMP);

    assign w_target = WIDTH'(align_word(PC_MAX_WIDTH'(w_target_raw)));

    always_comb begin
        w_pc_next = r_pc + c_INSN_STEP;
        case (w_src)
            SRC_RESET:  w_pc_next = RESET_VECTOR;
            SRC_EXC:    w_pc_next = EXC_VECTOR;
            SRC_ERET,
            SRC_BRANCH,
            SRC_RET,
            SRC_JUMP:   w_pc_next = w_target;
            SRC_HOLD:   w_pc_next = r_pc;
            default:    w_pc_next = r_pc + c_INSN_STEP;
        endcase
    end

    // ------------------------------------------------------------------
    // PC / EPC / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_valid    <= 1'b1;
            r_misalign <= w_redirect && (w_target_raw[1:0] != 2'b00);
            if (w_src == SRC_EXC) begin
                r_epc <= r_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return-address stack; the pushed link is the address after the call.
    // ------------------------------------------------------------------
    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (r_pc + c_INSN_STEP),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    assign pc_out    = r_pc;
    assign pc_valid  = r_valid;
    assign epc_out   = r_epc;
    assign ras_empty = w_ras_empty;
    assign ras_full  = w_ras_full;
    assign misalign  = r_misalign;

endmodule : pc_unit
`default_nettype wire
